// File: rtl/easyaxi_rd_mst_if.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_rd_mst_if
// Description : Bundles the user request/response channels, the AXI AR and R
//               channels and the status outputs of easyaxi_rd_mst.
//               master modport : seen from the read master (the DUT)
//               slave modport  : seen from the user / AXI slave side
// Ports       : req_*  user request   (valid/ready, addr, len, size, burst)
//               axi_ar* AXI read address channel
//               axi_r*  AXI read data channel
//               rsp_*  user response  (valid/ready, packed data, resp, len)
//               ost_cnt, proto_err status
// Revision    : 1.0 - initial release
// ============================================================================
interface easyaxi_rd_mst_if #(
    parameter int OST_DEPTH     = 4,
    parameter int ID_W          = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_BURST_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_BURST_LEN);
    localparam int CNT_W = $clog2(OST_DEPTH) + 1;

    logic                          req_valid;
    logic                          req_ready;
    logic [ADDR_W-1:0]             req_addr;
    logic [LEN_W-1:0]              req_len;
    logic [2:0]                    req_size;
    logic [1:0]                    req_burst;

    logic                          axi_arvalid;
    logic                          axi_arready;
    logic [ID_W-1:0]               axi_arid;
    logic [ADDR_W-1:0]             axi_araddr;
    logic [7:0]                    axi_arlen;
    logic [2:0]                    axi_arsize;
    logic [1:0]                    axi_arburst;

    logic                          axi_rvalid;
    logic                          axi_rready;
    logic [ID_W-1:0]               axi_rid;
    logic [DATA_W-1:0]             axi_rdata;
    logic [1:0]                    axi_rresp;
    logic                          axi_rlast;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DATA_W*MAX_BURST_LEN-1:0] rsp_data;
    logic [1:0]                    rsp_resp;
    logic [LEN_W-1:0]              rsp_len;

    logic [CNT_W-1:0]              ost_cnt;
    logic                          proto_err;

    modport master (
        input  req_valid, req_addr, req_len, req_size, req_burst,
        output req_ready,
        output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        output axi_rready,
        output rsp_valid, rsp_data, rsp_resp, rsp_len,
        input  rsp_ready,
        output ost_cnt, proto_err
    );

    modport slave (
        output req_valid, req_addr, req_len, req_size, req_burst,
        input  req_ready,
        input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_rready,
        input  rsp_valid, rsp_data, rsp_resp, rsp_len,
        output rsp_ready,
        input  ost_cnt, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/easyaxi_rd_mst.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_rd_mst
// Description : AXI read master with an OST_DEPTH-entry outstanding buffer.
//               Requests are allocated into a circular buffer, issued on AR
//               in order, filled by (possibly interleaved, out-of-order) R
//               bursts matched by RID = entry index, and returned to the user
//               as whole packed bursts in allocation order.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - easyaxi_rd_mst_if.master (request, AR, R, response,
//                        ost_cnt, sticky proto_err)
// Revision    : 1.0 - initial release
// ============================================================================
module easyaxi_rd_mst #(
    parameter int OST_DEPTH     = 4,
    parameter int ID_W          = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_BURST_LEN = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    easyaxi_rd_mst_if.master    bus
);
    localparam int LEN_W = $clog2(MAX_BURST_LEN);
    localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int CNT_W = $clog2(OST_DEPTH) + 1;
    localparam int BUF_W = DATA_W * MAX_BURST_LEN;

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(OST_DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OST_DEPTH);
    localparam logic [ID_W:0]    c_id_lim   = (ID_W+1)'(OST_DEPTH);

    // Per-entry state
    logic [OST_DEPTH-1:0] valid_q;
    logic [OST_DEPTH-1:0] pend_ar_q;
    logic [OST_DEPTH-1:0] pend_r_q;
    logic [ADDR_W-1:0]    addr_q  [OST_DEPTH];
    logic [LEN_W-1:0]     len_q   [OST_DEPTH];
    logic [2:0]           size_q  [OST_DEPTH];
    logic [1:0]           burst_q [OST_DEPTH];
    logic [BUF_W-1:0]     data_q  [OST_DEPTH];
    logic [LEN_W:0]       beat_q  [OST_DEPTH];
    logic [1:0]           resp_q  [OST_DEPTH];

    // Buffer pointers and occupancy
    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] issue_q, issue_d;
    logic [PTR_W-1:0] rel_q,   rel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q;

    logic             w_alloc;
    logic             w_ar_hs;
    logic             w_rel;
    logic             w_rid_ok;
    logic [PTR_W-1:0] w_ridx;
    logic             w_hit;
    logic [LEN_W:0]   w_beat;
    logic [LEN_W:0]   w_len1;
    logic             w_in_range;
    logic             w_drop;
    logic             w_err;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_idx) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Outputs: everything is read straight out of entry registers, so the
    // AR and response payloads are stable for as long as the selecting
    // pointer does not move (pointers move only on their handshakes).
    // ------------------------------------------------------------------
    assign bus.req_ready   = (cnt_q != c_full_cnt);
    assign bus.axi_arvalid = pend_ar_q[issue_q];
    assign bus.axi_arid    = ID_W'(issue_q);
    assign bus.axi_araddr  = addr_q[issue_q];
    assign bus.axi_arlen   = 8'(len_q[issue_q]);
    assign bus.axi_arsize  = size_q[issue_q];
    assign bus.axi_arburst = burst_q[issue_q];
    assign bus.axi_rready  = 1'b1;
    // pend_r is only cleared by rlast, which requires the AR to have issued
    assign bus.rsp_valid   = valid_q[rel_q] && !pend_r_q[rel_q];
    assign bus.rsp_data    = data_q[rel_q];
    assign bus.rsp_resp    = resp_q[rel_q];
    assign bus.rsp_len     = len_q[rel_q];
    assign bus.ost_cnt     = cnt_q;
    assign bus.proto_err   = err_q;

    assign w_alloc = bus.req_valid && bus.req_ready;
    assign w_ar_hs = bus.axi_arvalid && bus.axi_arready;
    assign w_rel   = bus.rsp_valid && bus.rsp_ready;

    // RID decode: only IDs below OST_DEPTH can name an entry
    assign w_rid_ok   = ({1'b0, bus.axi_rid} < c_id_lim);
    assign w_ridx     = bus.axi_rid[PTR_W-1:0];
    assign w_hit      = bus.axi_rvalid && w_rid_ok && valid_q[w_ridx]
                        && !pend_ar_q[w_ridx] && pend_r_q[w_ridx];
    assign w_beat     = beat_q[w_ridx];
    assign w_len1     = {1'b0, len_q[w_ridx]} + 1'b1;
    assign w_in_range = (w_beat < w_len1);
    // A surplus beat is discarded outright unless it carries rlast, in which
    // case it still terminates the burst so the entry can be delivered.
    assign w_drop     = w_hit && !bus.axi_rlast && !w_in_range;
    assign w_err      = (bus.axi_rvalid && !w_hit) || w_drop
                        || (w_hit && bus.axi_rlast && ((w_beat + 1'b1) != w_len1));

    always_comb begin
        alloc_d = w_alloc ? f_inc(alloc_q) : alloc_q;
        issue_d = w_ar_hs ? f_inc(issue_q) : issue_q;
        rel_d   = w_rel   ? f_inc(rel_q)   : rel_q;
        cnt_d   = cnt_q;
        if (w_alloc && !w_rel) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_alloc && w_rel) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Allocation, AR issue, R write and release never target the same entry
    // in one cycle (they require mutually exclusive flag states), so the
    // updates below do not conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            pend_ar_q <= '0;
            pend_r_q  <= '0;
            alloc_q   <= '0;
            issue_q   <= '0;
            rel_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                addr_q[i]  <= '0;
                len_q[i]   <= '0;
                size_q[i]  <= '0;
                burst_q[i] <= '0;
                data_q[i]  <= '0;
                beat_q[i]  <= '0;
                resp_q[i]  <= '0;
            end
        end else begin
            alloc_q <= alloc_d;
            issue_q <= issue_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;

            if (w_alloc) begin
                valid_q[alloc_q]   <= 1'b1;
                pend_ar_q[alloc_q] <= 1'b1;
                pend_r_q[alloc_q]  <= 1'b1;
                addr_q[alloc_q]    <= bus.req_addr;
                len_q[alloc_q]     <= bus.req_len;
                size_q[alloc_q]    <= bus.req_size;
                burst_q[alloc_q]   <= bus.req_burst;
                data_q[alloc_q]    <= '0;
                beat_q[alloc_q]    <= '0;
                resp_q[alloc_q]    <= '0;
            end

            if (w_ar_hs) begin
                pend_ar_q[issue_q] <= 1'b0;
            end

            if (w_hit && !w_drop) begin
                if (w_in_range) begin
                    data_q[w_ridx][w_beat[LEN_W-1:0]*DATA_W +: DATA_W] <= bus.axi_rdata;
                    beat_q[w_ridx] <= w_beat + 1'b1;
                end
                // Worst response wins: OKAY < EXOKAY < SLVERR < DECERR
                if (bus.axi_rresp > resp_q[w_ridx]) begin
                    resp_q[w_ridx] <= bus.axi_rresp;
                end
                if (bus.axi_rlast) begin
                    pend_r_q[w_ridx] <= 1'b0;
                end
            end

            if (w_rel) begin
                valid_q[rel_q] <= 1'b0;
            end

            if (w_err) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
